regfile_2w2r_sb: RTL and testbench
==================================

Name: regfile_2w2r_sb

Overview:
- Parametrised successor to the CPU's 16x16 register file.
- Provides DEPTH x DATA_W storage with two combinational read ports, two synchronous write ports, same-cycle write-to-read bypass, and a per-register busy scoreboard for the issue stage.
- Sits between decode/issue (reads, busy checks, marks) and writeback (two retire channels).

Parameters:
- DATA_W, 16, width of each register.
- ADDR_W, 4, register index width.
- DEPTH, 2**ADDR_W, number of registers. Must be 2..2**ADDR_W. Indices >= DEPTH read 0, and writes/marks to them are ignored.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- SrcReg1  in  ADDR_W  read port 1 index.
- SrcReg2  in  ADDR_W  read port 2 index.
- SrcData1  out  DATA_W  read port 1 data.
- SrcData2  out  DATA_W  read port 2 data.
- SrcBusy1  out  1  scoreboard busy bit for SrcReg1.
- SrcBusy2  out  1  scoreboard busy bit for SrcReg2.
- WriteRegA  in  1  write enable, channel A.
- DstRegA  in  ADDR_W  write index, channel A.
- DstDataA  in  DATA_W  write data, channel A.
- WriteRegB  in  1  write enable, channel B.
- DstRegB  in  ADDR_W  write index, channel B.
- DstDataB  in  DATA_W  write data, channel B.
- MarkEn  in  1  set busy bit of MarkReg (issue of a new producer).
- MarkReg  in  ADDR_W  register to mark busy.

Behaviour:
- Reset: rst sampled at rising clk; all registers <= 0 and all busy bits <= 0. Reset takes priority over writes and marks in the same cycle.
- While rst is high, SrcData1/2 = 0 and SrcBusy1/2 = 0, and bypass is suppressed.
- Write: on rising edge, reg[DstRegA] <= DstDataA if WriteRegA; reg[DstRegB] <= DstDataB if WriteRegB.
- Write conflict: if both enabled with DstRegA == DstRegB, channel B wins. Channel A's write to that index is dropped.
- Read: combinational, zero latency. SrcDataN = DstDataB if (WriteRegB && DstRegB == SrcRegN); else DstDataA if (WriteRegA && DstRegA == SrcRegN); else reg[SrcRegN].
- Read consequence: a value written this cycle is visible on the read ports in the same cycle and remains visible from storage after the edge.
- Scoreboard: busy[i] clears at the edge when any write channel targets i, and sets when MarkEn with MarkReg == i.
- Scoreboard conflict: if a mark and a write hit the same index in the same cycle, the mark wins and busy stays 1 (new producer supersedes the retiring one).
- Busy read: SrcBusyN = busy[SrcRegN] AND NOT (a write this cycle targets SrcRegN). The bypassed value is usable, so the operand is not reported busy.
- Busy read with same-cycle mark: a mark does not affect SrcBusyN until the following cycle.
- Out-of-range indices (>= DEPTH): read 0 and busy 0; writes and marks to them have no effect.
- No internal FSM beyond storage and scoreboard. All outputs are a pure function of state and current inputs.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to 0. Writes to index 0 on either channel are ignored and not bypassed. SrcDataN = 0 whenever SrcRegN == 0. MarkEn to index 0 is ignored, so busy[0] is always 0.
- Undefined: register 0 behaves like every other register.

Test Plan:
- Reset and readback: assert rst 2 cycles while WriteRegA=1, DstRegA=3, DstDataA=16'hBEEF. Deassert, read SrcReg1=3 -> SrcData1=0, SrcBusy1=0.
- Bypass: WriteRegA=1, DstRegA=5, DstDataA=16'h1234, SrcReg1=5 in the same cycle -> SrcData1=16'h1234 before the edge. Next cycle with no write -> SrcData1 still 16'h1234.
- Write conflict: WriteRegA=WriteRegB=1, both DstReg=7, DstDataA=16'hAAAA, DstDataB=16'h5555 -> same-cycle SrcData2 (SrcReg2=7) = 16'h5555, and reg[7] = 16'h5555 after the edge.
- Scoreboard: MarkEn=1, MarkReg=9 -> next cycle SrcBusy1 (SrcReg1=9) = 1. Then WriteRegB=1, DstRegB=9 -> SrcBusy1=0 in that cycle and 0 after. Mark+write to 9 in one cycle -> busy[9]=1 after the edge.
- Zero register (REGFILE_ZERO_REG_EN defined): write 16'hFFFF to index 0 and MarkEn index 0 -> SrcData1=0 and SrcBusy1=0 both same cycle and after. With the macro undefined -> SrcData1=16'hFFFF.
- Random regression: 1000 cycles of random writes, marks and reads against a reference model, with occasional mid-run rst pulses -> exact match on SrcData1/2 and SrcBusy1/2 every cycle.

Source files
------------

// File: rtl/regfile_2w2r_sb_if.sv
// Register file bus: two read ports with busy flags, two writeback
// channels and the issue-stage mark port.
// master: decode/issue + writeback side; slave: the register file.
interface regfile_2w2r_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic [ADDR_W-1:0] SrcReg1;
  logic [ADDR_W-1:0] SrcReg2;
  logic [DATA_W-1:0] SrcData1;
  logic [DATA_W-1:0] SrcData2;
  logic              SrcBusy1;
  logic              SrcBusy2;

  logic              WriteRegA;
  logic [ADDR_W-1:0] DstRegA;
  logic [DATA_W-1:0] DstDataA;
  logic              WriteRegB;
  logic [ADDR_W-1:0] DstRegB;
  logic [DATA_W-1:0] DstDataB;

  logic              MarkEn;
  logic [ADDR_W-1:0] MarkReg;

  modport master (
    output SrcReg1, SrcReg2,
    output WriteRegA, DstRegA, DstDataA,
    output WriteRegB, DstRegB, DstDataB,
    output MarkEn, MarkReg,
    input  SrcData1, SrcData2, SrcBusy1, SrcBusy2
  );

  modport slave (
    input  SrcReg1, SrcReg2,
    input  WriteRegA, DstRegA, DstDataA,
    input  WriteRegB, DstRegB, DstDataB,
    input  MarkEn, MarkReg,
    output SrcData1, SrcData2, SrcBusy1, SrcBusy2
  );

endinterface

// File: rtl/regfile_2w2r_sb.sv
// DEPTH x DATA_W register file: two combinational read ports with
// same-cycle write bypass, two synchronous write channels (B wins on
// index conflict) and a per-register busy scoreboard.
// Optional macro REGFILE_ZERO_REG_EN: register 0 hardwired to zero,
// writes/marks to index 0 ignored and never bypassed.
// Indices >= DEPTH read as 0 / not busy; writes and marks to them are dropped.
module regfile_2w2r_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input logic              clk,
  input logic              rst,
  regfile_2w2r_sb_if.slave bus
);

  // Storage is sized to the full index space so every index is a legal
  // array select; entries >= DEPTH are never written and stay at reset 0.
  localparam int NREG = 2**ADDR_W;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] mem [NREG];
  logic [NREG-1:0]   busy;

  logic wr_a;
  logic wr_b;
  logic mk;
  logic hit_a1, hit_b1, hit_a2, hit_b2;

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return (int'(idx) < DEPTH);
  endfunction

  // Effective enables: out-of-range and (optionally) index-0 targets are dropped.
  always_comb begin
    wr_a = bus.WriteRegA && in_range(bus.DstRegA) && !(ZERO_REG && (bus.DstRegA == '0));
    wr_b = bus.WriteRegB && in_range(bus.DstRegB) && !(ZERO_REG && (bus.DstRegB == '0));
    mk   = bus.MarkEn    && in_range(bus.MarkReg) && !(ZERO_REG && (bus.MarkReg == '0));
  end

  // Same-cycle write hits on each read index, shared by data bypass and busy masking.
  always_comb begin
    hit_a1 = wr_a && (bus.DstRegA == bus.SrcReg1);
    hit_b1 = wr_b && (bus.DstRegB == bus.SrcReg1);
    hit_a2 = wr_a && (bus.DstRegA == bus.SrcReg2);
    hit_b2 = wr_b && (bus.DstRegB == bus.SrcReg2);
  end

  // Read ports: channel B bypass, then channel A bypass, then storage; all zero in reset.
  always_comb begin
    bus.SrcData1 = '0;
    bus.SrcData2 = '0;
    if (!rst) begin
      if (ZERO_REG && (bus.SrcReg1 == '0)) begin
        bus.SrcData1 = '0;
      end else if (hit_b1) begin
        bus.SrcData1 = bus.DstDataB;
      end else if (hit_a1) begin
        bus.SrcData1 = bus.DstDataA;
      end else if (in_range(bus.SrcReg1)) begin
        bus.SrcData1 = mem[bus.SrcReg1];
      end

      if (ZERO_REG && (bus.SrcReg2 == '0)) begin
        bus.SrcData2 = '0;
      end else if (hit_b2) begin
        bus.SrcData2 = bus.DstDataB;
      end else if (hit_a2) begin
        bus.SrcData2 = bus.DstDataA;
      end else if (in_range(bus.SrcReg2)) begin
        bus.SrcData2 = mem[bus.SrcReg2];
      end
    end
  end

  // Busy flags: a retiring write this cycle makes the operand usable via bypass;
  // a same-cycle mark only shows up after the edge.
  always_comb begin
    bus.SrcBusy1 = 1'b0;
    bus.SrcBusy2 = 1'b0;
    if (!rst) begin
      bus.SrcBusy1 = in_range(bus.SrcReg1) && busy[bus.SrcReg1] && !(hit_a1 || hit_b1);
      bus.SrcBusy2 = in_range(bus.SrcReg2) && busy[bus.SrcReg2] && !(hit_a2 || hit_b2);
    end
  end

  // Storage update; on an index conflict channel A's write is suppressed so B lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_a && !(wr_b && (bus.DstRegB == bus.DstRegA))) begin
        mem[bus.DstRegA] <= bus.DstDataA;
      end
      if (wr_b) begin
        mem[bus.DstRegB] <= bus.DstDataB;
      end
    end
  end

  // Scoreboard update; a new producer's mark overrides a retiring write to the same index.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (mk && (bus.MarkReg == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if ((wr_a && (bus.DstRegA == ADDR_W'(i))) ||
                     (wr_b && (bus.DstRegB == ADDR_W'(i)))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Self-checking bench for regfile_2w2r_sb: directed scenarios with fixed
// expectations, then a randomized run against a behavioural model.
// DEPTH is set below the index space so out-of-range indices get exercised.
module tb_regfile_2w2r_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int NREG   = 16;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZMODE = 1'b1;
`else
  localparam bit ZMODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_2w2r_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_2w2r_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: architectural register values and busy flags.
  logic [DATA_W-1:0] m_reg  [NREG];
  bit                m_busy [NREG];

  function automatic bit target_ok(input bit en, input int idx);
    return en && (idx < DEPTH) && !(ZMODE && idx == 0);
  endfunction

  // Model state advance on each rising edge from the inputs held across it.
  always @(posedge clk) begin : model_edge
    int a, b, m;
    bit wa, wb;
    a  = int'(bus.DstRegA);
    b  = int'(bus.DstRegB);
    m  = int'(bus.MarkReg);
    wa = target_ok(bus.WriteRegA, a);
    wb = target_ok(bus.WriteRegB, b);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wa && !(wb && a == b)) m_reg[a] = bus.DstDataA;
      if (wb) m_reg[b] = bus.DstDataB;
      if (wa) m_busy[a] = 1'b0;
      if (wb) m_busy[b] = 1'b0;
      if (target_ok(bus.MarkEn, m)) m_busy[m] = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] exp_data(input int src);
    if (rst) return '0;
    if (src >= DEPTH || (ZMODE && src == 0)) return '0;
    if (target_ok(bus.WriteRegB, int'(bus.DstRegB)) && int'(bus.DstRegB) == src) return bus.DstDataB;
    if (target_ok(bus.WriteRegA, int'(bus.DstRegA)) && int'(bus.DstRegA) == src) return bus.DstDataA;
    return m_reg[src];
  endfunction

  function automatic logic exp_busy(input int src);
    if (rst || src >= DEPTH) return 1'b0;
    if (target_ok(bus.WriteRegB, int'(bus.DstRegB)) && int'(bus.DstRegB) == src) return 1'b0;
    if (target_ok(bus.WriteRegA, int'(bus.DstRegA)) && int'(bus.DstRegA) == src) return 1'b0;
    return m_busy[src];
  endfunction

  task automatic idle();
    bus.SrcReg1   = '0;
    bus.SrcReg2   = '0;
    bus.WriteRegA = 1'b0;
    bus.DstRegA   = '0;
    bus.DstDataA  = '0;
    bus.WriteRegB = 1'b0;
    bus.DstRegB   = '0;
    bus.DstDataB  = '0;
    bus.MarkEn    = 1'b0;
    bus.MarkReg   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd3;
    bus.DstDataA  = 16'hBEEF;
    bus.SrcReg1   = 4'd3;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_no_bypass: SrcData1 got %h want %h", bus.SrcData1, 16'h0000);
    end
    tick();
    tick();
    rst = 1'b0;
    idle();
    bus.SrcReg1 = 4'd3;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_readback: SrcData1 got %h want %h", bus.SrcData1, 16'h0000);
    end
    n_cmp++;
    if (bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: SrcBusy1 got %b want %b", bus.SrcBusy1, 1'b0);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd5;
    bus.DstDataA  = 16'h1234;
    bus.SrcReg1   = 4'd5;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h1234) begin
      n_err++;
      $display("FAIL bypass_same_cycle: SrcData1 got %h want %h", bus.SrcData1, 16'h1234);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd5;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h1234) begin
      n_err++;
      $display("FAIL bypass_after_edge: SrcData1 got %h want %h", bus.SrcData1, 16'h1234);
    end
  endtask

  task automatic test_write_conflict();
    idle();
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd7;
    bus.DstDataA  = 16'hAAAA;
    bus.WriteRegB = 1'b1;
    bus.DstRegB   = 4'd7;
    bus.DstDataB  = 16'h5555;
    bus.SrcReg2   = 4'd7;
    #1;
    n_cmp++;
    if (bus.SrcData2 !== 16'h5555) begin
      n_err++;
      $display("FAIL conflict_bypass: SrcData2 got %h want %h", bus.SrcData2, 16'h5555);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd7;
    bus.SrcReg2 = 4'd7;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h5555 || bus.SrcData2 !== 16'h5555) begin
      n_err++;
      $display("FAIL conflict_stored: SrcData1/2 got %h/%h want %h", bus.SrcData1, bus.SrcData2, 16'h5555);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    bus.WriteRegB = 1'b1;
    bus.DstRegB   = 4'd4;
    bus.DstDataB  = 16'h1111;
    tick();
    idle();
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd4;
    bus.DstDataA  = 16'h2222;
    bus.SrcReg1   = 4'd4;
    bus.SrcReg2   = 4'd4;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h2222) begin
      n_err++;
      $display("FAIL b2b_bypass: SrcData1 got %h want %h", bus.SrcData1, 16'h2222);
    end
    tick();
    idle();
    bus.SrcReg2 = 4'd4;
    #1;
    n_cmp++;
    if (bus.SrcData2 !== 16'h2222) begin
      n_err++;
      $display("FAIL b2b_stored: SrcData2 got %h want %h", bus.SrcData2, 16'h2222);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.MarkEn  = 1'b1;
    bus.MarkReg = 4'd9;
    bus.SrcReg1 = 4'd9;
    #1;
    n_cmp++;
    if (bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL sb_mark_same_cycle: SrcBusy1 got %b want %b", bus.SrcBusy1, 1'b0);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd9;
    #1;
    n_cmp++;
    if (bus.SrcBusy1 !== 1'b1) begin
      n_err++;
      $display("FAIL sb_mark_next: SrcBusy1 got %b want %b", bus.SrcBusy1, 1'b1);
    end
    bus.WriteRegB = 1'b1;
    bus.DstRegB   = 4'd9;
    bus.DstDataB  = 16'h0909;
    #1;
    n_cmp++;
    if (bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL sb_retire_same_cycle: SrcBusy1 got %b want %b", bus.SrcBusy1, 1'b0);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd9;
    #1;
    n_cmp++;
    if (bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL sb_retire_after: SrcBusy1 got %b want %b", bus.SrcBusy1, 1'b0);
    end
    bus.MarkEn    = 1'b1;
    bus.MarkReg   = 4'd9;
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd9;
    bus.DstDataA  = 16'h9999;
    tick();
    idle();
    bus.SrcReg2 = 4'd9;
    #1;
    n_cmp++;
    if (bus.SrcBusy2 !== 1'b1) begin
      n_err++;
      $display("FAIL sb_mark_beats_write: SrcBusy2 got %b want %b", bus.SrcBusy2, 1'b1);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd13;
    bus.DstDataA  = 16'h1357;
    bus.WriteRegB = 1'b1;
    bus.DstRegB   = 4'(DEPTH - 1);
    bus.DstDataB  = 16'h2468;
    bus.MarkEn    = 1'b1;
    bus.MarkReg   = 4'd14;
    bus.SrcReg1   = 4'd13;
    bus.SrcReg2   = 4'(DEPTH - 1);
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h0000) begin
      n_err++;
      $display("FAIL oor_no_bypass: SrcData1 got %h want %h", bus.SrcData1, 16'h0000);
    end
    n_cmp++;
    if (bus.SrcData2 !== 16'h2468) begin
      n_err++;
      $display("FAIL last_index_bypass: SrcData2 got %h want %h", bus.SrcData2, 16'h2468);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd14;
    bus.SrcReg2 = 4'(DEPTH - 1);
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h0000 || bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL oor_mark: SrcData1/SrcBusy1 got %h/%b want %h/%b", bus.SrcData1, bus.SrcBusy1, 16'h0000, 1'b0);
    end
    n_cmp++;
    if (bus.SrcData2 !== 16'h2468) begin
      n_err++;
      $display("FAIL last_index_stored: SrcData2 got %h want %h", bus.SrcData2, 16'h2468);
    end
    bus.SrcReg1 = 4'd13;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== 16'h0000) begin
      n_err++;
      $display("FAIL oor_write: SrcData1 got %h want %h", bus.SrcData1, 16'h0000);
    end
  endtask

  task automatic test_zero_reg();
    logic [DATA_W-1:0] want_d;
    logic              want_b;
    want_d = ZMODE ? 16'h0000 : 16'hFFFF;
    want_b = ZMODE ? 1'b0 : 1'b1;
    idle();
    bus.WriteRegA = 1'b1;
    bus.DstRegA   = 4'd0;
    bus.DstDataA  = 16'hFFFF;
    bus.MarkEn    = 1'b1;
    bus.MarkReg   = 4'd0;
    bus.SrcReg1   = 4'd0;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== want_d || bus.SrcBusy1 !== 1'b0) begin
      n_err++;
      $display("FAIL zero_same_cycle: SrcData1/SrcBusy1 got %h/%b want %h/%b", bus.SrcData1, bus.SrcBusy1, want_d, 1'b0);
    end
    tick();
    idle();
    bus.SrcReg1 = 4'd0;
    #1;
    n_cmp++;
    if (bus.SrcData1 !== want_d || bus.SrcBusy1 !== want_b) begin
      n_err++;
      $display("FAIL zero_after_edge: SrcData1/SrcBusy1 got %h/%b want %h/%b", bus.SrcData1, bus.SrcBusy1, want_d, want_b);
    end
  endtask

  task automatic test_random();
    int dmis;
    dmis = 0;
    idle();
    rst = 1'b1;
    tick();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      rst           = ($urandom_range(0, 49) == 0);
      bus.WriteRegA = ($urandom_range(0, 1) == 1);
      bus.DstRegA   = 4'($urandom_range(0, NREG - 1));
      bus.DstDataA  = 16'($urandom_range(0, 65535));
      bus.WriteRegB = ($urandom_range(0, 1) == 1);
      bus.DstRegB   = 4'($urandom_range(0, NREG - 1));
      bus.DstDataB  = 16'($urandom_range(0, 65535));
      bus.MarkEn    = ($urandom_range(0, 2) == 0);
      bus.MarkReg   = 4'($urandom_range(0, NREG - 1));
      bus.SrcReg1   = 4'($urandom_range(0, NREG - 1));
      bus.SrcReg2   = 4'($urandom_range(0, NREG - 1));
      #1;
      n_cmp++;
      if (bus.SrcData1 !== exp_data(int'(bus.SrcReg1))) begin
        n_err++;
        if (dmis++ < 10) $display("FAIL rand_data1 cyc %0d: got %h want %h", cyc, bus.SrcData1, exp_data(int'(bus.SrcReg1)));
      end
      n_cmp++;
      if (bus.SrcData2 !== exp_data(int'(bus.SrcReg2))) begin
        n_err++;
        if (dmis++ < 10) $display("FAIL rand_data2 cyc %0d: got %h want %h", cyc, bus.SrcData2, exp_data(int'(bus.SrcReg2)));
      end
      n_cmp++;
      if (bus.SrcBusy1 !== exp_busy(int'(bus.SrcReg1))) begin
        n_err++;
        if (dmis++ < 10) $display("FAIL rand_busy1 cyc %0d: got %b want %b", cyc, bus.SrcBusy1, exp_busy(int'(bus.SrcReg1)));
      end
      n_cmp++;
      if (bus.SrcBusy2 !== exp_busy(int'(bus.SrcReg2))) begin
        n_err++;
        if (dmis++ < 10) $display("FAIL rand_busy2 cyc %0d: got %b want %b", cyc, bus.SrcBusy2, exp_busy(int'(bus.SrcReg2)));
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_bypass();
    test_write_conflict();
    test_back_to_back();
    test_scoreboard();
    test_out_of_range();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
